// File: rtl/col_crop_pkg.sv
// img_stream_pkg: shared FSM state type and constants for the column-crop stage.
// Rev 1.0
`default_nettype none

package img_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } state_t;

  localparam int c_PAD_MIN = 1;
  localparam int c_PAD_MAX = 8;
  localparam int c_SOF_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/col_crop_if.sv
// col_crop_if: AXI-stream bundle (tuser/tdest/tvalid/tready/tlast/tdata) with master/slave views.
// Rev 1.0
`default_nettype none

interface col_crop_if #(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8
) ();

  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tuser, tdest, tvalid, tlast, tdata, input tready);
  modport slave  (input tuser, tdest, tvalid, tlast, tdata, output tready);

endinterface

`default_nettype wire

// File: rtl/col_crop_dly.sv
// col_crop_dly: PAD-deep enabled shift register; o_data is the entry shifted in PAD enables ago.
// Rev 1.0
`default_nettype none

module col_crop_dly #(
  parameter int PAD   = 2,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic             i_flush,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_sr [PAD];

  // Flush wins over shift so the tail pad of a finished row never leaks into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PAD; k++) r_sr[k] <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < PAD; k++) r_sr[k] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_data;
      for (int k = 1; k < PAD; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_data = r_sr[PAD-1];

endmodule

`default_nettype wire

// File: rtl/col_crop.sv
// col_crop: strips PAD pixels from head and tail of each AXI-stream row, regenerating tlast.
// Rev 1.0 -- COL_CROP_LEN_CHECK_EN adds cfg_in_width / sticky err_len row-length check.
`default_nettype none

module col_crop
  import img_stream_pkg::*;
#(
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8,
  parameter int PAD         = 2,
  parameter int CNT_WIDTH   = 12
) (
  input  wire logic    clk,
  input  wire logic    rst,
  col_crop_if.slave    s_axis,
  col_crop_if.master   m_axis
`ifdef COL_CROP_LEN_CHECK_EN
  ,
  input  wire logic [CNT_WIDTH-1:0] cfg_in_width,
  output logic                      err_len
`endif
);

  localparam logic [CNT_WIDTH-1:0] c_HEAD_END = CNT_WIDTH'(2 * PAD - 1);
  localparam logic [CNT_WIDTH-1:0] c_COL_MAX  = '1;

  if (PAD < c_PAD_MIN || PAD > c_PAD_MAX) begin : g_pad_range
    $error("col_crop: PAD outside legal range");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_col;
  logic [TUSER_WIDTH-1:0] r_cap_user;
  logic [TDEST_WIDTH-1:0] r_cap_dest;
  logic                   r_m_tvalid;
  logic                   r_m_tlast;
  logic [TDATA_WIDTH-1:0] r_m_tdata;
  logic [TUSER_WIDTH-1:0] r_m_tuser;
  logic [TDEST_WIDTH-1:0] r_m_tdest;
  logic [TDATA_WIDTH-1:0] w_dly_out;
  logic                   w_acc;
  logic                   w_row_end;
  logic                   w_capture;
  logic                   w_emit;

  assign s_axis.tready = ~r_m_tvalid | m_axis.tready;
  assign w_acc         = s_axis.tvalid & s_axis.tready;
  assign w_row_end     = w_acc & s_axis.tlast;

  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tlast  = r_m_tlast;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tuser  = r_m_tuser;
  assign m_axis.tdest  = r_m_tdest;

  col_crop_dly #(
    .PAD   (PAD),
    .WIDTH (TDATA_WIDTH)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_acc),
    .i_flush (w_row_end),
    .i_data  (s_axis.tdata),
    .o_data  (w_dly_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_acc) begin
      case (r_state)
        S_IDLE:  w_next = s_axis.tlast ? S_IDLE : S_HEAD;
        S_HEAD: begin
          if (s_axis.tlast)              w_next = S_IDLE;
          else if (r_col == c_HEAD_END)  w_next = S_BODY;
        end
        S_BODY:  if (s_axis.tlast) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture = 1'b0;
    w_emit    = 1'b0;
    if (w_acc) begin
      w_capture = (r_state == S_IDLE);
      w_emit    = (r_state == S_BODY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
    end else if (w_acc) begin
      if (s_axis.tlast)           r_col <= '0;
      else if (r_col != c_COL_MAX) r_col <= r_col + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_user <= '0;
      r_cap_dest <= '0;
    end else if (w_capture) begin
      r_cap_user <= s_axis.tuser;
      r_cap_dest <= s_axis.tdest;
    end
  end

  // An accept always implies the output slot is free, so loading on w_emit never overwrites a stalled beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tdest  <= '0;
    end else if (w_emit) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= s_axis.tlast;
      r_m_tdata  <= w_dly_out;
      r_m_tuser  <= r_cap_user;
      r_m_tdest  <= r_cap_dest;
    end else if (m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef COL_CROP_LEN_CHECK_EN
  logic             r_err_len;
  logic [CNT_WIDTH:0] w_row_len;

  assign w_row_len = {1'b0, r_col} + (CNT_WIDTH+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                r_err_len <= 1'b0;
    else if (w_row_end && (w_row_len != {1'b0, cfg_in_width})) r_err_len <= 1'b1;
  end

  assign err_len = r_err_len;
`endif

endmodule

`default_nettype wire

// File: tb/tb_col_crop.sv
// tb_col_crop: directed self-checking bench for col_crop with PAD=2.
// Rev 1.0
`default_nettype none

module tb_col_crop;
  import img_stream_pkg::*;

  localparam int PAD       = 2;
  localparam int CNT_WIDTH = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  col_crop_if #(.TUSER_WIDTH(5), .TDEST_WIDTH(2), .TDATA_WIDTH(8)) s_if ();
  col_crop_if #(.TUSER_WIDTH(5), .TDEST_WIDTH(2), .TDATA_WIDTH(8)) m_if ();

`ifdef COL_CROP_LEN_CHECK_EN
  logic [CNT_WIDTH-1:0] cfg_in_width = 12'd12;
  logic                 err_len;
`endif

  col_crop #(
    .TUSER_WIDTH (5),
    .TDEST_WIDTH (2),
    .TDATA_WIDTH (8),
    .PAD         (PAD),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axis (s_if),
    .m_axis (m_if)
`ifdef COL_CROP_LEN_CHECK_EN
    ,
    .cfg_in_width (cfg_in_width),
    .err_len      (err_len)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q_data [$];
  logic       q_last [$];
  logic [4:0] q_user [$];
  logic [1:0] q_dest [$];
  int         q_cyc  [$];
  int         cyc = 0;
  int         stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [16:0] stall_saved = '0;

  // Records every handshaken output beat and flags any change of m_* during a stall.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && ({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest} !== stall_saved))
        stall_err++;
      stall_prev  = m_if.tvalid & ~m_if.tready;
      stall_saved = {m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest};
      if (m_if.tvalid && m_if.tready) begin
        q_data.push_back(m_if.tdata);
        q_last.push_back(m_if.tlast);
        q_user.push_back(m_if.tuser);
        q_dest.push_back(m_if.tdest);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_user.delete(); q_dest.delete(); q_cyc.delete();
    stall_err = 0;
  endtask

  // Sends len beats starting at value first; tlast on the final beat only when with_last is set.
  task automatic drive_row(input int first, input int len, input bit with_last,
                           input logic [4:0] user, input logic [1:0] dest, input bit toggle);
    int   b = 0;
    int   guard = 0;
    logic rdy;
    while (b < len && guard < 500) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(first + b);
      s_if.tlast  = with_last && (b == len - 1);
      s_if.tuser  = (b == 0) ? user : 5'd0;
      s_if.tdest  = dest;
      m_if.tready = toggle ? ~m_if.tready : 1'b1;
      #1;
      rdy = s_if.tready;
      @(posedge clk);
      if (rdy) b++;
      guard++;
    end
    checks++;
    if (b != len) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d beats, required %0d", b, len);
    end
  endtask

  task automatic drain(input int n, input bit toggle);
    repeat (n) begin
      @(negedge clk);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = toggle ? ~m_if.tready : 1'b1;
    end
    repeat (4) begin
      @(negedge clk);
      m_if.tready = 1'b1;
    end
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tdest = '0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tuser, m_if.tdest});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b, required 1", s_if.tready);
    end
  endtask

  task automatic test_basic();
    clear_q();
    drive_row(0, 12, 1'b1, 5'h01, 2'd1, 1'b0);
    drain(10, 1'b0);
    checks++;
    if (q_data.size() != 8) begin
      errors++;
      $display("FAIL basic_count: got %0d beats, required 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_data[k] !== 8'(2 + k) || q_last[k] !== (k == 7) || q_user[k][c_SOF_BIT] !== 1'b1 ||
            q_dest[k] !== 2'd1) begin
          errors++;
          $display("FAIL basic_beat%0d: got data=%0d last=%b user=%h dest=%0d, required data=%0d last=%b user=01 dest=1",
                   k, q_data[k], q_last[k], q_user[k], q_dest[k], 2 + k, (k == 7));
        end
      end
      checks++;
      if (q_cyc[7] - q_cyc[0] != 7) begin
        errors++;
        $display("FAIL basic_bubbles: 8 beats spanned %0d cycles, required 7", q_cyc[7] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    drive_row(0, 12, 1'b1, 5'h01, 2'd1, 1'b1);
    drain(40, 1'b1);
    checks++;
    if (q_data.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, required 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_data[k] !== 8'(2 + k) || q_last[k] !== (k == 7) || q_user[k] !== 5'h01) begin
          errors++;
          $display("FAIL bp_beat%0d: got data=%0d last=%b user=%h, required data=%0d last=%b user=01",
                   k, q_data[k], q_last[k], q_user[k], 2 + k, (k == 7));
        end
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d stall cycles changed m_axis, required 0", stall_err);
    end
  endtask

  task automatic test_short_row();
    clear_q();
    drive_row(10, 4, 1'b1, 5'h01, 2'd3, 1'b0);
    drive_row(20, 12, 1'b1, 5'h02, 2'd2, 1'b0);
    drain(10, 1'b0);
    checks++;
    if (q_data.size() != 8) begin
      errors++;
      $display("FAIL short_count: got %0d beats, required 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_data[k] !== 8'(22 + k) || q_last[k] !== (k == 7) || q_user[k] !== 5'h02 ||
            q_dest[k] !== 2'd2) begin
          errors++;
          $display("FAIL short_beat%0d: got data=%0d last=%b user=%h dest=%0d, required data=%0d last=%b user=02 dest=2",
                   k, q_data[k], q_last[k], q_user[k], q_dest[k], 22 + k, (k == 7));
        end
      end
    end
  endtask

  task automatic test_single_beat();
    clear_q();
    drive_row(40, 5, 1'b1, 5'h01, 2'd0, 1'b0);
    drain(8, 1'b0);
    checks++;
    if (q_data.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d beats, required 1", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 8'd42 || q_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_beat: got data=%0d last=%b, required data=42 last=1", q_data[0], q_last[0]);
      end
    end
  endtask

  task automatic test_reset_mid_row();
    drive_row(0, 7, 1'b0, 5'h01, 2'd1, 1'b0);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: got tvalid=%b tdata=%0d, required 0/0", m_if.tvalid, m_if.tdata);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    @(negedge clk);
    checks++;
    if (s_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_tready: got %b, required 1", s_if.tready);
    end
    drive_row(50, 12, 1'b1, 5'h01, 2'd1, 1'b0);
    drain(10, 1'b0);
    checks++;
    if (q_data.size() != 8) begin
      errors++;
      $display("FAIL rst_count: got %0d beats, required 8", q_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (q_data[k] !== 8'(52 + k) || q_last[k] !== (k == 7)) begin
          errors++;
          $display("FAIL rst_beat%0d: got data=%0d last=%b, required data=%0d last=%b",
                   k, q_data[k], q_last[k], 52 + k, (k == 7));
        end
      end
    end
  endtask

`ifdef COL_CROP_LEN_CHECK_EN
  task automatic test_len_check();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_row(0, 12, 1'b1, 5'h01, 2'd0, 1'b0);
    drain(4, 1'b0);
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL len_ok: got err_len=%b, required 0", err_len);
    end
    drive_row(0, 11, 1'b1, 5'h01, 2'd0, 1'b0);
    drain(4, 1'b0);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_bad: got err_len=%b, required 1", err_len);
    end
    drive_row(0, 12, 1'b1, 5'h01, 2'd0, 1'b0);
    drain(4, 1'b0);
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL len_sticky: got err_len=%b, required 1", err_len);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_row();
    test_single_beat();
    test_reset_mid_row();
`ifdef COL_CROP_LEN_CHECK_EN
    test_len_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
